// File: rtl/pic_cpu_pkg.sv
// Shared definitions for the PIC-style mini-CPU core: overflow policy
// constants, stack operation encoding and small elaboration/modular helpers.
package pic_cpu_pkg;

  // Overflow/underflow policy selector values for the return-address stack.
  localparam int OVF_WRAP = 0;  // circular, PIC-compatible
  localparam int OVF_SAT  = 1;  // reject the operation, keep state

  // Decoded stack operation for one cycle.
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_e;

  // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // (v + 1) mod m for v already in 0..m-1; no reliance on power-of-two m.
  function automatic int inc_mod(input int v, input int m);
    return (v == m - 1) ? 0 : v + 1;
  endfunction

  // (v - 1) mod m for v already in 0..m-1.
  function automatic int dec_mod(input int v, input int m);
    return (v == 0) ? m - 1 : v - 1;
  endfunction

  // (v - k) mod m for v in 0..m-1 and any non-negative k.
  function automatic int sub_mod(input int v, input int k, input int m);
    return (v + m - (k % m)) % m;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Parametrised hardware return-address stack. Push on CALL, pop on RETLW;
// top of stack is combinational from the registers so a return completes
// in one cycle. Overflow policy is OVF_WRAP (circular) or OVF_SAT (reject).
// Optional debugger peek port enabled with macro PC_STACK_PEEK_EN.
module pc_stack
  import pic_cpu_pkg::*;
#(
  parameter int AW       = 9,
  parameter int DEPTH    = 2,
  parameter int OVF_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                din,
  output logic [AW-1:0]                dout,
  output logic [clog2(DEPTH+1)-1:0]    count,
  output logic                         empty,
  output logic                         full,
  input  logic                         err_clr,
  output logic                         ovf_err,
  output logic                         unf_err
`ifdef PC_STACK_PEEK_EN
  ,
  input  logic [clog2(DEPTH)-1:0]      peek_idx,
  output logic [AW-1:0]                peek_data
`endif
);

  localparam int CW       = clog2(DEPTH + 1);
  localparam int PW       = clog2(DEPTH);
  localparam bit SATURATE = (OVF_MODE == OVF_SAT);

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [PW-1:0] sp_inc, sp_dec;
  logic          is_empty, is_full;
  stack_op_e     op;

  // Pointer neighbours and occupancy status; sp_dec also addresses the top.
  always_comb begin
    sp_inc   = PW'(inc_mod(int'(sp_q), DEPTH));
    sp_dec   = PW'(dec_mod(int'(sp_q), DEPTH));
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
  end

  // Decode the request; push+pop on an empty stack is treated as a plain push.
  always_comb begin
    op = OP_NONE;
    if (push && pop && !is_empty) op = OP_REPLACE;
    else if (push)                op = OP_PUSH;
    else if (pop)                 op = OP_POP;
  end

  // Next-state for storage, pointer, occupancy and sticky error flags.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned
    // and infers a latch; blocking '=' is correct inside combinational logic.
    mem_d   = mem_q;
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;

    unique case (op)
      OP_REPLACE: begin
        mem_d[sp_dec] = din;
      end
      OP_PUSH: begin
        if (!is_full) begin
          mem_d[sp_q] = din;
          sp_d        = sp_inc;
          count_d     = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            // Overwrite the oldest entry; occupancy stays at DEPTH.
            mem_d[sp_q] = din;
            sp_d        = sp_inc;
          end
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          sp_d    = sp_dec;
          count_d = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
          if (!SATURATE) sp_d = sp_dec;
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is reset as well, because the top of stack is
      // visible unmasked and must read 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' for all flops so every register samples the
      // pre-edge values regardless of statement order.
      mem_q   <= mem_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Outputs straight from the registers: zero-latency top of stack.
  always_comb begin
    dout    = mem_q[sp_dec];
    count   = count_q;
    empty   = is_empty;
    full    = is_full;
    ovf_err = ovf_q;
    unf_err = unf_q;
  end

`ifdef PC_STACK_PEEK_EN
  // Debugger view of the entry peek_idx positions below the top.
  always_comb begin
    peek_data = mem_q[PW'(sub_mod(int'(sp_q), 1 + int'(peek_idx), DEPTH))];
  end
`endif

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack (AW=9, DEPTH=2). Two instances share the
// stimulus: one with the circular overflow policy, one saturating.
// Build with PC_STACK_PEEK_EN defined to also exercise the peek port.
module tb_pc_stack;

  logic       clk = 1'b0;
  logic       rst;
  logic       push, pop, err_clr;
  logic [8:0] din;

  logic [8:0] w_dout, s_dout;
  logic [1:0] w_count, s_count;
  logic       w_empty, w_full, w_ovf, w_unf;
  logic       s_empty, s_full, s_ovf, s_unf;
`ifdef PC_STACK_PEEK_EN
  logic [0:0] peek_idx;
  logic [8:0] w_peek, s_peek;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_stack #(.AW(9), .DEPTH(2), .OVF_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(w_dout), .count(w_count), .empty(w_empty), .full(w_full),
    .err_clr(err_clr), .ovf_err(w_ovf), .unf_err(w_unf)
`ifdef PC_STACK_PEEK_EN
    , .peek_idx(peek_idx), .peek_data(w_peek)
`endif
  );

  pc_stack #(.AW(9), .DEPTH(2), .OVF_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(s_dout), .count(s_count), .empty(s_empty), .full(s_full),
    .err_clr(err_clr), .ovf_err(s_ovf), .unf_err(s_unf)
`ifdef PC_STACK_PEEK_EN
    , .peek_idx(peek_idx), .peek_data(s_peek)
`endif
  );

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [8:0] din;
    logic [8:0] dout;
    logic [1:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic p, input logic q, input logic c,
                              input logic [8:0] d, input logic [8:0] o,
                              input logic [1:0] n, input logic e, input logic f,
                              input logic ov, input logic un);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.din = d; v.dout = o;
    v.count = n; v.empty = e; v.full = f; v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endfunction

  // One clocked operation; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic p, input logic q, input logic [8:0] d, input logic c);
    push = p; pop = q; din = d; err_clr = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
`ifdef PC_STACK_PEEK_EN
    peek_idx = '0;
`endif

    // Circular-policy sequence from reset:  p  q  c  din     dout    cnt e  f  ovf unf
    add(1, 0, 0, 9'h123, 9'h123, 2'd1, 0, 0, 0, 0);
    add(1, 0, 0, 9'h045, 9'h045, 2'd2, 0, 1, 0, 0);
    add(0, 1, 0, 9'h000, 9'h123, 2'd1, 0, 0, 0, 0);
    add(0, 1, 0, 9'h000, 9'h045, 2'd0, 1, 0, 0, 0);
    add(1, 0, 0, 9'h001, 9'h001, 2'd1, 0, 0, 0, 0);
    add(1, 0, 0, 9'h002, 9'h002, 2'd2, 0, 1, 0, 0);
    add(1, 0, 0, 9'h003, 9'h003, 2'd2, 0, 1, 1, 0);  // overwrite oldest
    add(0, 1, 0, 9'h000, 9'h002, 2'd1, 0, 0, 1, 0);
    add(0, 1, 0, 9'h000, 9'h003, 2'd0, 1, 0, 1, 0);  // circular top
    add(0, 0, 1, 9'h000, 9'h003, 2'd0, 1, 0, 0, 0);  // clear ovf
    add(1, 1, 0, 9'h010, 9'h010, 2'd1, 0, 0, 0, 0);  // push+pop on empty
    add(0, 1, 0, 9'h000, 9'h003, 2'd0, 1, 0, 0, 0);
    add(1, 0, 0, 9'h0AA, 9'h0AA, 2'd1, 0, 0, 0, 0);
    add(1, 1, 0, 9'h155, 9'h155, 2'd1, 0, 0, 0, 0);  // replace top
    add(0, 1, 0, 9'h000, 9'h003, 2'd0, 1, 0, 0, 0);
    add(0, 1, 0, 9'h000, 9'h155, 2'd0, 1, 0, 0, 1);  // underflow, sp wraps
    add(0, 1, 1, 9'h000, 9'h003, 2'd0, 1, 0, 0, 1);  // error beats clear
    add(0, 0, 1, 9'h000, 9'h003, 2'd0, 1, 0, 0, 0);  // clear alone

    // Reset state, sampled between edges while reset is held.
    #12;
    check("rst.w_dout",  w_dout,  9'h000);
    check("rst.w_count", w_count, 2'd0);
    check("rst.w_empty", w_empty, 1'b1);
    check("rst.w_full",  w_full,  1'b0);
    check("rst.w_flags", {w_ovf, w_unf}, 2'b00);
    check("rst.s_count", s_count, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
      check($sformatf("v%0d.dout", i),  w_dout,  vecs[i].dout);
      check($sformatf("v%0d.count", i), w_count, vecs[i].count);
      check($sformatf("v%0d.empty", i), w_empty, vecs[i].empty);
      check($sformatf("v%0d.full", i),  w_full,  vecs[i].full);
      check($sformatf("v%0d.ovf", i),   w_ovf,   vecs[i].ovf);
      check($sformatf("v%0d.unf", i),   w_unf,   vecs[i].unf);
    end

    // Saturating policy: third push is rejected.
    do_reset();
    cycle(1, 0, 9'h001, 0);
    cycle(1, 0, 9'h002, 0);
    cycle(1, 0, 9'h003, 0);
    check("sat.dout",  s_dout,  9'h002);
    check("sat.count", s_count, 2'd2);
    check("sat.full",  s_full,  1'b1);
    check("sat.ovf",   s_ovf,   1'b1);

    // Saturating policy: underflow leaves the pointer alone.
    do_reset();
    cycle(0, 1, 9'h000, 0);
    check("sat_unf.unf",   s_unf,   1'b1);
    check("sat_unf.count", s_count, 2'd0);
    check("sat_unf.dout",  s_dout,  9'h000);
    cycle(1, 0, 9'h077, 0);
    check("sat_unf.push_dout",  s_dout,  9'h077);
    check("sat_unf.push_count", s_count, 2'd1);

    // Async reset mid-cycle with a full stack and a pending overflow flag.
    do_reset();
    cycle(1, 0, 9'h00A, 0);
    cycle(1, 0, 9'h00B, 0);
`ifdef PC_STACK_PEEK_EN
    peek_idx = 1'b1;
    #1;
    check("peek.idx1", w_peek, 9'h00A);
    peek_idx = 1'b0;
    #1;
    check("peek.idx0", w_peek, 9'h00B);
`endif
    cycle(1, 0, 9'h00C, 0);
    check("pre_arst.count", w_count, 2'd2);
    check("pre_arst.ovf",   w_ovf,   1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("arst.count", w_count, 2'd0);
    check("arst.empty", w_empty, 1'b1);
    check("arst.full",  w_full,  1'b0);
    check("arst.dout",  w_dout,  9'h000);
    check("arst.flags", {w_ovf, w_unf, s_ovf, s_unf}, 4'b0000);
    check("arst.s_count", s_count, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
